arb8_round_robin: RTL and testbench

Arbiter that shares one downstream resource among 8 requesters. It uses the codebase's 8-input priority-encoding convention: index 7 is the highest fixed priority and the winner is reported as a 3-bit ID. It adds registered one-hot grants, grant hold with a timeout, a turnaround gap, and optional round-robin fairness. It sits between the requesting channels and the shared datapath, replacing a bare priority encoder wherever the encoded output must be held and sequenced.

---
 rtl/arb8_round_robin.sv | 112 +++++++++++
 tb/tb_arb8_round_robin.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/arb8_round_robin.sv
// rtl/arb8_round_robin.sv - 8-way arbiter with registered one-hot grant, hold timeout and turnaround gap
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin winner search; default is fixed priority (index 7 highest).

module arb8_round_robin #(
  parameter int NUM_REQ  = 8,
  parameter int ID_W     = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout,
  output logic               busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]      state;
  logic [CNT_W-1:0] hold_cnt;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] win_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_idx;

  // Walk the search order backwards so the earliest set bit after last_id is the final assignment.
  always_comb begin
    win_id = '0;
    rr_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rr_idx = last_id + ID_W'(1) + ID_W'(i);
      if (req[rr_idx]) begin
        win_id = rr_idx;
      end
    end
  end
`else
  logic unused_last_id;
  assign unused_last_id = ^last_id;

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        win_id = ID_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      last_id   <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            gnt       <= NUM_REQ'(1) << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        GRANT: begin
          // Other request lines are ignored here: a grant is never preempted.
          if (!req[gnt_id] || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= req[gnt_id];
            last_id   <= gnt_id;
            state     <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          timeout <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          gnt       <= '0;
          gnt_valid <= 1'b0;
          timeout   <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb8_round_robin.sv
// tb/tb_arb8_round_robin.sv - directed self-checking bench for arb8_round_robin (MAX_HOLD=4)

module tb_arb8_round_robin;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic       busy;

  int total = 0;
  int bad   = 0;

  arb8_round_robin #(.NUM_REQ(8), .ID_W(3), .MAX_HOLD(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_id(gnt_id),
    .gnt_valid(gnt_valid), .timeout(timeout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req   = 8'h00;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    total++; if (gnt !== 8'h00) begin bad++; $display("FAIL reset_gnt got=%h want=%h", gnt, 8'h00); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", gnt_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", gnt_id); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    req = 8'h01;
    tick();
    total++; if (gnt !== 8'h01) begin bad++; $display("FAIL basic_gnt got=%h want=01", gnt); end
    total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL basic_id got=%0d want=0", gnt_id); end
    total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", gnt_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    tick();
    tick();
    total++; if (gnt !== 8'h01) begin bad++; $display("FAIL basic_hold got=%h want=01", gnt); end
    req = 8'h00;
    tick();
    total++; if (gnt !== 8'h00) begin bad++; $display("FAIL basic_rel_gnt got=%h want=00", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_rel_busy got=%b want=1", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL basic_rel_timeout got=%b want=0", timeout); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_valid got=%b want=0", gnt_valid); end
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_order();
    logic [2:0] exp_id;
    apply_reset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      exp_id = 3'(n);
      tick();
      total++; if (gnt !== (8'h01 << exp_id)) begin bad++; $display("FAIL rr_gnt[%0d] got=%h want=%h", n, gnt, 8'h01 << exp_id); end
      total++; if (gnt_id !== exp_id) begin bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", n, gnt_id, exp_id); end
      req = 8'hFF & ~(8'h01 << exp_id);
      tick();
      total++; if (gnt !== 8'h00) begin bad++; $display("FAIL rr_gap1[%0d] got=%h want=00", n, gnt); end
      req = 8'hFF;
      tick();
      total++; if (gnt !== 8'h00) begin bad++; $display("FAIL rr_gap2[%0d] got=%h want=00", n, gnt); end
    end
    req = 8'h00;
    tick();
    tick();
    tick();
  endtask
`else
  task automatic test_order();
    logic [2:0] ids [3];
    ids[0] = 3'd5; ids[1] = 3'd2; ids[2] = 3'd1;
    req = 8'h26;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++; if (gnt !== (8'h01 << ids[n])) begin bad++; $display("FAIL fix_gnt[%0d] got=%h want=%h", n, gnt, 8'h01 << ids[n]); end
      total++; if (gnt_id !== ids[n]) begin bad++; $display("FAIL fix_id[%0d] got=%0d want=%0d", n, gnt_id, ids[n]); end
      tick();
      total++; if (gnt_id !== ids[n] || gnt_valid !== 1'b1) begin bad++; $display("FAIL fix_hold[%0d] got=%0d/%b want=%0d/1", n, gnt_id, gnt_valid, ids[n]); end
      req = req & ~(8'h01 << ids[n]);
      tick();
      total++; if (gnt !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL fix_gap1[%0d] got=%h/%b want=00/1", n, gnt, busy); end
      tick();
      total++; if (gnt !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL fix_gap2[%0d] got=%h/%b want=00/0", n, gnt, busy); end
    end
  endtask
`endif

  task automatic test_timeout();
    req = 8'h80;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (gnt !== 8'h80) begin bad++; $display("FAIL to_gnt[%0d] got=%h want=80", c, gnt); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early[%0d] got=%b want=0", c, timeout); end
    end
    tick();
    total++; if (gnt !== 8'h00) begin bad++; $display("FAIL to_drop got=%h want=00", gnt); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", timeout); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy got=%b want=1", busy); end
    tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_end got=%b want=0", timeout); end
    total++; if (gnt !== 8'h00) begin bad++; $display("FAIL to_gap2 got=%h want=00", gnt); end
    tick();
    total++; if (gnt !== 8'h80) begin bad++; $display("FAIL to_regrant got=%h want=80", gnt); end
    total++; if (gnt_id !== 3'd7) begin bad++; $display("FAIL to_regrant_id got=%0d want=7", gnt_id); end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    req = 8'h10;
    tick();
    total++; if (gnt !== 8'h10) begin bad++; $display("FAIL rmg_pre got=%h want=10", gnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 8'h00) begin bad++; $display("FAIL rmg_gnt got=%h want=00", gnt); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL rmg_valid got=%b want=0", gnt_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmg_busy got=%b want=0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 8'h10) begin bad++; $display("FAIL rmg_regrant got=%h want=10", gnt); end
    total++; if (gnt_id !== 3'd4) begin bad++; $display("FAIL rmg_regrant_id got=%0d want=4", gnt_id); end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_no_preempt();
    req = 8'h02;
    tick();
    total++; if (gnt !== 8'h02) begin bad++; $display("FAIL np_first got=%h want=02", gnt); end
    req = 8'h82;
    tick();
    total++; if (gnt !== 8'h02) begin bad++; $display("FAIL np_hold1 got=%h want=02", gnt); end
    tick();
    total++; if (gnt !== 8'h02) begin bad++; $display("FAIL np_hold2 got=%h want=02", gnt); end
    req = 8'h80;
    tick();
    total++; if (gnt !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL np_release got=%h/%b want=00/1", gnt, busy); end
    tick();
    total++; if (gnt !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL np_idle got=%h/%b want=00/0", gnt, busy); end
    tick();
    total++; if (gnt !== 8'h80) begin bad++; $display("FAIL np_next got=%h want=80", gnt); end
    total++; if (gnt_id !== 3'd7) begin bad++; $display("FAIL np_next_id got=%0d want=7", gnt_id); end
    req = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    req   = 8'h00;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_order();
    test_timeout();
    test_reset_mid_grant();
    test_no_preempt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
